// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the VGA framebuffer controller: write FSM states,
// mode bit positions and pixel/lane sizing helpers.
package vga_fb_pkg;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} wr_state_e;

  localparam int MODE_ORIENT = 0;
  localparam int MODE_LANE   = 1;

  function automatic int calc_ppw(input int word_w, input int pix_w);
    return word_w / pix_w;
  endfunction

  // Lane index width; a single-lane word still needs a 1-bit select.
  function automatic int lane_w(input int ppw);
    return (ppw > 1) ? $clog2(ppw) : 1;
  endfunction

endpackage

// File: rtl/vga_fb_rmw.sv
// Pixel write engine: read-modify-write of one lane inside a memory word.
// Exposes its FSM state for checkers.
module vga_fb_rmw import vga_fb_pkg::*; #(
  parameter int PIX_W  = 8,
  parameter int WORD_W = 32,
  parameter int AW     = 18,
  parameter int RD_LAT = 1,
  localparam int PPW   = calc_ppw(WORD_W, PIX_W),
  localparam int LW    = lane_w(PPW),
  localparam int MW    = AW - $clog2(PPW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [AW-1:0]     wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              lane_big,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              wr_ready,
  output logic              done,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [MW-1:0]     wr_word,
  output wr_state_e         state
);

  // wr_valid/wr_ready: a request transfers on a cycle where both are high;
  // wr_ready is high only in IDLE, so exactly one request is taken per write.
  localparam int LS = $clog2(PPW);

  wr_state_e         state_next;
  logic [AW-1:0]     addr_q;
  logic [PIX_W-1:0]  data_q;
  logic              big_q;
  logic [1:0]        rd_cnt;
  logic [LW-1:0]     lane_k;
  logic [LW-1:0]     lane_pos;
  logic [WORD_W-1:0] merged;

  assign wr_word  = MW'(addr_q >> LS);
  assign lane_k   = LW'(addr_q % AW'(PPW));
  assign lane_pos = big_q ? (LW'(PPW - 1) - lane_k) : lane_k;

  always_comb begin
    merged = mem_rdata;
    merged[lane_pos*PIX_W +: PIX_W] = data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      big_q     <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state  <= state_next;
      rd_cnt <= (state == RD) ? rd_cnt + 2'd1 : 2'd0;
      if (state == IDLE && wr_valid) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
        big_q  <= lane_big;
      end
      if (state == MERGE) mem_wdata <= merged;
    end
  end

  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (wr_valid) state_next = RD;
      end
      RD:    if (rd_cnt == 2'(RD_LAT - 1)) state_next = MERGE;
      MERGE: state_next = WR;
      WR: begin
        mem_we     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/vga_fb_ctrl.sv
// VGA framebuffer controller: display-side word fetch and lane extraction plus
// pixel read-modify-write. Optional test pattern behind VGA_FB_CTRL_TESTPAT_EN.
module vga_fb_ctrl import vga_fb_pkg::*; #(
  parameter int PIX_W   = 8,
  parameter int WORD_W  = 32,
  parameter int IMG_W   = 512,
  parameter int IMG_H   = 512,
  parameter int RD_LAT  = 1,
  parameter int CLK_DIV = 2,
  localparam int PPW    = calc_ppw(WORD_W, PIX_W),
  localparam int AW     = $clog2(IMG_W * IMG_H),
  localparam int MW     = $clog2(IMG_W * IMG_H / PPW)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef VGA_FB_CTRL_TESTPAT_EN
  input  logic              testpat_on,
`endif
  input  logic [1:0]        mode,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              wr_valid,
  input  logic [AW-1:0]     wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  output logic              done,
  output logic [MW-1:0]     mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              pclk_en,
  output logic [PIX_W-1:0]  pix_color
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int LW = lane_w(PPW);
  localparam int LS = $clog2(PPW);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  wr_state_e        state;
  logic [MW-1:0]    wr_word;
  logic [AW-1:0]    disp_idx;
  logic [MW-1:0]    disp_word;
  logic [LW-1:0]    disp_k;
  logic [LW-1:0]    disp_pos;
  logic             disp_oor;
  logic [LW-1:0]    pos_pipe [RD_LAT];
  logic             ok_pipe  [RD_LAT];
  logic [PIX_W-1:0] fb_pix;
  logic [DW-1:0]    div_cnt;

  vga_fb_rmw #(
    .PIX_W (PIX_W),
    .WORD_W(WORD_W),
    .AW    (AW),
    .RD_LAT(RD_LAT)
  ) u_rmw (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .lane_big (mode[MODE_LANE]),
    .mem_rdata(mem_rdata),
    .wr_ready (wr_ready),
    .done     (done),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .wr_word  (wr_word),
    .state    (state)
  );

  // Image sides are powers of two, so the linear index is a bit concatenation.
  assign disp_idx  = mode[MODE_ORIENT] ? {x[XW-1:0], y[YW-1:0]} : {y[YW-1:0], x[XW-1:0]};
  assign disp_oor  = (32'(x) >= IMG_W) || (32'(y) >= IMG_H);
  assign disp_word = MW'(disp_idx >> LS);
  assign disp_k    = LW'(disp_idx % AW'(PPW));
  assign disp_pos  = mode[MODE_LANE] ? (LW'(PPW - 1) - disp_k) : disp_k;
  assign mem_addr  = (state == IDLE) ? disp_word : wr_word;

  // Lane select and validity travel alongside the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pos_pipe[i] <= '0;
        ok_pipe[i]  <= 1'b0;
      end
    end else begin
      pos_pipe[0] <= disp_pos;
      ok_pipe[0]  <= (state == IDLE) && !disp_oor;
      for (int i = 1; i < RD_LAT; i++) begin
        pos_pipe[i] <= pos_pipe[i-1];
        ok_pipe[i]  <= ok_pipe[i-1];
      end
    end
  end

  assign fb_pix = ok_pipe[RD_LAT-1] ? mem_rdata[pos_pipe[RD_LAT-1]*PIX_W +: PIX_W] : '0;

`ifdef VGA_FB_CTRL_TESTPAT_EN
  assign pix_color = testpat_on ? PIX_W'(x[7:0] ^ y[7:0]) : fb_pix;
`else
  assign pix_color = fb_pix;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pclk_en <= 1'b0;
    end else begin
      pclk_en <= (div_cnt == DW'(CLK_DIV - 1));
      div_cnt <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
    end
  end

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Self-checking bench for vga_fb_ctrl: behavioural word memory, randomized
// pixel writes and display reads compared against an arithmetic reference.
module tb_vga_fb_ctrl;

  localparam int PIX_W   = 8;
  localparam int WORD_W  = 32;
  localparam int IMG_W   = 512;
  localparam int IMG_H   = 512;
  localparam int RD_LAT  = 1;
  localparam int CLK_DIV = 2;
  localparam int PPW     = WORD_W / PIX_W;
  localparam int AW      = 18;
  localparam int MW      = 16;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode = '0;
  logic [9:0]        x = '0;
  logic [9:0]        y = '0;
  logic              wr_valid = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic              wr_ready;
  logic              done;
  logic [MW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata = '0;
  logic              pclk_en;
  logic [PIX_W-1:0]  pix_color;
`ifdef VGA_FB_CTRL_TESTPAT_EN
  logic              testpat_on = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_fb_ctrl #(
    .PIX_W(PIX_W), .WORD_W(WORD_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .RD_LAT(RD_LAT), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef VGA_FB_CTRL_TESTPAT_EN
    .testpat_on(testpat_on),
`endif
    .mode     (mode),
    .x        (x),
    .y        (y),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .pclk_en  (pclk_en),
    .pix_color(pix_color)
  );

  // ---------------- memory and reference model ----------------
  logic [WORD_W-1:0] ram     [int];
  logic [WORD_W-1:0] ref_mem [int];
  logic [WORD_W-1:0] last_wdata;
  int                wr_hist [$];

  function automatic logic [WORD_W-1:0] seed_word(input int a);
    return WORD_W'(a * 32'h9E3779B1 ^ 32'h5A5A5A5A);
  endfunction

  function automatic logic [WORD_W-1:0] ram_rd(input int a);
    return ram.exists(a) ? ram[a] : seed_word(a);
  endfunction

  function automatic logic [WORD_W-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
    mem_rdata <= ram_rd(int'(mem_addr));
  end

  function automatic int disp_idx(input int xx, input int yy, input logic [1:0] m);
    return m[0] ? xx * IMG_H + yy : yy * IMG_W + xx;
  endfunction

  function automatic int lane_pos(input int idx, input logic big);
    return big ? (PPW - 1 - (idx % PPW)) : (idx % PPW);
  endfunction

  function automatic logic [WORD_W-1:0] merge(input logic [WORD_W-1:0] w, input int pos,
                                              input logic [PIX_W-1:0] d);
    logic [WORD_W-1:0] mask;
    mask = WORD_W'((1 << PIX_W) - 1) << (pos * PIX_W);
    return (w & ~mask) | (WORD_W'(d) << (pos * PIX_W));
  endfunction

  function automatic logic [PIX_W-1:0] exp_pix(input int xx, input int yy, input logic [1:0] m);
    int idx;
    logic [WORD_W-1:0] w;
    if (xx >= IMG_W || yy >= IMG_H) return '0;
    idx = disp_idx(xx, yy, m);
    w   = ref_rd(idx / PPW);
    return PIX_W'(w >> (lane_pos(idx, m[1]) * PIX_W));
  endfunction

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [PIX_W-1:0] d, input logic [1:0] m);
    logic [WORD_W-1:0] exp_w;
    int we_at, done_at, we_cnt;
    exp_w   = merge(ref_rd(a / PPW), lane_pos(a, m[1]), d);
    we_at   = -1;
    done_at = -1;
    we_cnt  = 0;
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    mode     = m;
    #1;
    chk("wr_ready_idle", wr_ready, 1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      wr_valid = 1'b0;
      #1;
      if (c == 2) chk("pix_busy", pix_color, 0);
      if (mem_we) begin
        we_cnt++;
        if (we_at < 0) begin
          we_at = c;
          chk("we_addr", mem_addr, a / PPW);
          chk("we_data", mem_wdata, exp_w);
          last_wdata = mem_wdata;
        end
      end
      if (done && done_at < 0) done_at = c;
    end
    chk("we_latency", we_at, RD_LAT + 2);
    chk("done_latency", done_at, RD_LAT + 3);
    chk("we_once", we_cnt, 1);
    ref_mem[a / PPW] = exp_w;
  endtask

  task automatic disp_check(input int xx, input int yy, input logic [1:0] m);
    x    = 10'(xx);
    y    = 10'(yy);
    mode = m;
    #1;
    if (xx < IMG_W && yy < IMG_H) chk("disp_addr", mem_addr, disp_idx(xx, yy, m) / PPW);
    tick();
    chk("pix_color", pix_color, exp_pix(xx, yy, m));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a, xx, yy, highs, dbl, sel;
    logic prev;
    logic [PIX_W-1:0] d;
    logic [1:0] m;
    logic [WORD_W-1:0] exp_w;
    logic saw_we, saw_done;
    int we_q[$];
    int done_q[$];

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_pix", pix_color, 0);
    chk("rst_pclk", pclk_en, 0);
    chk("rst_wr_ready", wr_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // free-running pixel clock enable
    highs = 0;
    dbl   = 0;
    prev  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pclk_en) highs++;
      if (pclk_en && prev) dbl++;
      prev = pclk_en;
    end
    chk("pclk_count", highs, 20 / CLK_DIV);
    chk("pclk_adjacent", dbl, 0);

    // directed lane merge, little then big lane order
    ram[1] = 32'h11223344;
    ref_mem[1] = 32'h11223344;
    do_write(5, 8'hAB, 2'b00);
    chk("merge_little", last_wdata, 32'h1122AB44);
    ram[1] = 32'h11223344;
    ref_mem[1] = 32'h11223344;
    do_write(5, 8'hAB, 2'b10);
    chk("merge_big", last_wdata, 32'h11AB3344);

    // directed display fetch
    ram[129] = 32'hDDCCBBAA;
    ref_mem[129] = 32'hDDCCBBAA;
    disp_check(6, 1, 2'b00);
    chk("disp6_1_addr", mem_addr, 129);
    chk("disp6_1_pix", pix_color, 8'hCC);
    disp_check(600, 3, 2'b00);
    chk("oor_pix", pix_color, 0);

    // randomized writes
    for (int i = 0; i < 16; i++) begin
      a = $urandom_range(0, 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, IMG_W * IMG_H - 1));
      d = PIX_W'($urandom);
      m = 2'($urandom_range(0, 3));
      do_write(a, d, m);
      wr_hist.push_back(a);
    end

    // randomized display reads, half aimed at written pixels
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom_range(0, 3));
      if (i % 2 == 1) begin
        sel = $urandom_range(0, wr_hist.size() - 1);
        a = wr_hist[sel];
        if (m[0]) begin
          xx = a / IMG_H;
          yy = a % IMG_H;
        end else begin
          xx = a % IMG_W;
          yy = a / IMG_W;
        end
      end else begin
        xx = $urandom_range(0, 639);
        yy = $urandom_range(0, 599);
      end
      disp_check(xx, yy, m);
    end

    // reset while in MERGE aborts the write
    x = 10'd0;
    y = 10'd0;
    a = 1000;
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = 8'h5C;
    mode     = 2'b00;
    tick();
    wr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    saw_we   = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (mem_we) saw_we = 1'b1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_we", saw_we, 0);
    chk("abort_no_done", saw_done, 0);
    chk("abort_idle", wr_ready, 1);
    chk("abort_ram", ram_rd(a / PPW), ref_rd(a / PPW));

    // wr_valid held through DONE: second write starts right after DONE
    a = 2050;
    d = 8'h3E;
    exp_w = merge(ref_rd(a / PPW), lane_pos(a, 1'b1), d);
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    mode     = 2'b10;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 4) chk("hold_busy", wr_ready, 0);
      if (c == 5) chk("hold_ready", wr_ready, 1);
      if (mem_we) begin
        we_q.push_back(c);
        chk("hold_we_data", mem_wdata, exp_w);
      end
      if (done) done_q.push_back(c);
      if (c == 6) wr_valid = 1'b0;
    end
    ref_mem[a / PPW] = exp_w;
    chk("hold_we_count", we_q.size(), 2);
    chk("hold_done_count", done_q.size(), 2);
    if (we_q.size() == 2) begin
      chk("hold_we1", we_q[0], RD_LAT + 2);
      chk("hold_we2", we_q[1], RD_LAT + 7);
    end
    if (done_q.size() == 2) chk("hold_done2", done_q[1], RD_LAT + 8);
    disp_check(a % IMG_W, a / IMG_W, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, tests %0d", n_tests);
    $fatal(1);
  end

endmodule
